// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the two-port L2 arbiter.
// The grant selection helper lives here so the arbitration rule sits in one place.
package l2_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Round-robin pick: under contention the side that was not served last wins.
  function automatic arb_state_t pick_serve(logic i_req, logic d_req, grant_t last);
    arb_state_t nxt;
    nxt = IDLE;
    if (i_req && d_req)
      nxt = (last == GRANT_D) ? SERVE_I : SERVE_D;
    else if (i_req)
      nxt = SERVE_I;
    else if (d_req)
      nxt = SERVE_D;
    return nxt;
  endfunction

endpackage

// File: rtl/l2_arbiter_sat_counter.sv
// Saturating up-counter: increments on inc, holds once it reaches all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the L1 I-cache and D-cache in front of the L2.
// State is registered; L2 commands and responses are routed combinationally from the held inputs.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count
);

  // state   | meaning
  // IDLE    | no grant; L2 commands low; sample requests at the edge
  // SERVE_I | I-cache granted; wait for l2_resp
  // SERVE_D | D-cache granted; wait for l2_resp
  arb_state_t state;
  grant_t     last_grant;
  logic       d_req;
  logic       i_done;
  logic       d_done;

  assign d_req  = d_read | d_write;
  assign i_done = (state == SERVE_I) && l2_resp;
  assign d_done = (state == SERVE_D) && l2_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      case (state)
        IDLE: state <= pick_serve(i_read, d_req, last_grant);
        SERVE_I: begin
          if (l2_resp) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
          end
        end
        SERVE_D: begin
          if (l2_resp) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A withdrawn command simply drags the L2 command low; the grant is held until l2_resp.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    case (state)
      SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_resp     = l2_resp;
        i_rdata    = l2_rdata;
      end
      SERVE_D: begin
        l2_read    = d_read & ~d_write;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        d_rdata    = l2_rdata;
      end
      default: ;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (i_done),
    .count (i_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_done),
    .count (d_count)
  );

  a_i_held: assert property (@(posedge clk) disable iff (rst) (state == SERVE_I) |-> i_read)
    else $error("I-cache request withdrawn before l2_resp");
  a_d_held: assert property (@(posedge clk) disable iff (rst) (state == SERVE_D) |-> d_req)
    else $error("D-cache request withdrawn before l2_resp");

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: main instance with 16-bit counters, second with 2-bit counters.
module tb_l2_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic          i_read, d_read, d_write, l2_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, l2_rdata;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic [AW-1:0] l2_address;
  logic [15:0]   i_count, d_count;

  logic          s_i_read, s_d_read, s_d_write, s_l2_resp;
  logic [AW-1:0] s_i_address, s_d_address;
  logic [LW-1:0] s_d_wdata, s_l2_rdata;
  logic          s_i_resp, s_d_resp, s_l2_read, s_l2_write;
  logic [LW-1:0] s_i_rdata, s_d_rdata, s_l2_wdata;
  logic [AW-1:0] s_l2_address;
  logic [1:0]    s_i_count, s_d_count;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_count(i_count), .d_count(d_count)
  );

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_read(s_i_read), .i_address(s_i_address), .i_resp(s_i_resp), .i_rdata(s_i_rdata),
    .d_read(s_d_read), .d_write(s_d_write), .d_address(s_d_address), .d_wdata(s_d_wdata),
    .d_resp(s_d_resp), .d_rdata(s_d_rdata),
    .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_address(s_l2_address), .l2_wdata(s_l2_wdata),
    .l2_resp(s_l2_resp), .l2_rdata(s_l2_rdata),
    .i_count(s_i_count), .d_count(s_d_count)
  );

  task automatic test_reset();
    i_read = 1'b1; i_address = 32'h0000_0040;
    @(negedge clk); #1;
    tests_run++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_address !== '0 || l2_wdata !== '0 ||
        i_rdata !== '0 || d_rdata !== '0 || i_count !== 16'd0 || d_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h ic=%0d dc=%0d, want all 0",
               l2_read, l2_write, l2_address, i_count, d_count);
    end
    @(negedge clk); rst = 1'b0; i_read = 1'b0; i_address = '0;
  endtask

  task automatic test_lone_i_read();
    @(negedge clk); i_read = 1'b1; i_address = 32'h0000_1000; #1;
    tests_run++;
    if (l2_read !== 1'b0) begin
      tests_failed++; $display("FAIL lone_i_pre_grant: l2_read=%b want 0", l2_read);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) begin l2_resp = 1'b1; l2_rdata = {32{8'hA5}}; end
      #1;
      tests_run++;
      if ({l2_read, l2_write, l2_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
        tests_failed++;
        $display("FAIL lone_i_cmd c%0d: rd=%b wr=%b addr=%h want 1 0 00001000", k, l2_read, l2_write, l2_address);
      end
      tests_run++;
      if ({i_resp, d_resp} !== {(k == 5), 1'b0}) begin
        tests_failed++;
        $display("FAIL lone_i_resp c%0d: i_resp=%b d_resp=%b want %b 0", k, i_resp, d_resp, (k == 5));
      end
    end
    tests_run++;
    if (i_rdata !== {32{8'hA5}} || d_rdata !== '0) begin
      tests_failed++; $display("FAIL lone_i_rdata: i_rdata=%h d_rdata=%h", i_rdata, d_rdata);
    end
    @(negedge clk); i_read = 1'b0; l2_resp = 1'b0; l2_rdata = '0; #1;
    tests_run++;
    if (l2_read !== 1'b0 || i_resp !== 1'b0 || i_count !== 16'd1 || d_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL lone_i_after: rd=%b i_resp=%b ic=%0d dc=%0d want 0 0 1 0", l2_read, i_resp, i_count, d_count);
    end
  endtask

  task automatic test_lone_d_write();
    @(negedge clk); d_write = 1'b1; d_address = 32'h0000_2020; d_wdata = {16{16'h1234}};
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) l2_resp = 1'b1;
      #1;
      tests_run++;
      if ({l2_read, l2_write, l2_address} !== {1'b0, 1'b1, 32'h0000_2020} || l2_wdata !== {16{16'h1234}}) begin
        tests_failed++;
        $display("FAIL lone_d_cmd c%0d: rd=%b wr=%b addr=%h wdata=%h", k, l2_read, l2_write, l2_address, l2_wdata);
      end
      tests_run++;
      if ({d_resp, i_resp} !== {(k == 3), 1'b0}) begin
        tests_failed++;
        $display("FAIL lone_d_resp c%0d: d_resp=%b i_resp=%b want %b 0", k, d_resp, i_resp, (k == 3));
      end
    end
    @(negedge clk); d_write = 1'b0; l2_resp = 1'b0; #1;
    tests_run++;
    if ({l2_read, l2_write, d_resp} !== 3'b0 || d_count !== 16'd1 || i_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL lone_d_after: rd=%b wr=%b d_resp=%b dc=%0d ic=%0d want 0 0 0 1 1",
               l2_read, l2_write, d_resp, d_count, i_count);
    end
  endtask

  task automatic test_contention();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_3000; d_read = 1'b1; d_address = 32'h0000_4040;
    @(negedge clk); #1;
    tests_run++;
    if ({l2_read, l2_write, l2_address} !== {1'b1, 1'b0, 32'h0000_3000}) begin
      tests_failed++; $display("FAIL contention_first_i: rd=%b wr=%b addr=%h", l2_read, l2_write, l2_address);
    end
    @(negedge clk); l2_resp = 1'b1; l2_rdata = {8{32'h0BAD_F00D}}; #1;
    tests_run++;
    if ({i_resp, d_resp} !== 2'b10 || i_rdata !== {8{32'h0BAD_F00D}}) begin
      tests_failed++; $display("FAIL contention_i_resp: i_resp=%b d_resp=%b i_rdata=%h", i_resp, d_resp, i_rdata);
    end
    @(negedge clk); l2_resp = 1'b0; i_read = 1'b0; #1;
    tests_run++;
    if ({l2_read, l2_write} !== 2'b00) begin
      tests_failed++; $display("FAIL contention_turnaround: rd=%b wr=%b want 0 0", l2_read, l2_write);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({l2_read, l2_write, l2_address} !== {1'b1, 1'b0, 32'h0000_4040}) begin
      tests_failed++; $display("FAIL contention_then_d: rd=%b wr=%b addr=%h", l2_read, l2_write, l2_address);
    end
    l2_resp = 1'b1; #1;
    tests_run++;
    if ({d_resp, i_resp} !== 2'b10 || d_rdata !== {8{32'h0BAD_F00D}} || i_rdata !== '0) begin
      tests_failed++; $display("FAIL contention_d_resp: d_resp=%b i_resp=%b d_rdata=%h", d_resp, i_resp, d_rdata);
    end
    @(negedge clk); l2_resp = 1'b0; d_read = 1'b0; l2_rdata = '0; #1;
    tests_run++;
    if (i_count !== 16'd1 || d_count !== 16'd1) begin
      tests_failed++; $display("FAIL contention_counts: ic=%0d dc=%0d want 1 1", i_count, d_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h0000_5000;
    d_write = 1'b1; d_address = 32'h0000_6000; d_wdata = {8{32'hDEAD_BEEF}};
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); l2_resp = 1'b1; #1;
      tests_run++;
      if ((n % 2) == 0) begin
        if ({l2_read, l2_write, l2_address, i_resp, d_resp} !== {1'b1, 1'b0, 32'h0000_5000, 1'b1, 1'b0}) begin
          tests_failed++;
          $display("FAIL b2b_grant_i n%0d: rd=%b wr=%b addr=%h ir=%b dr=%b", n, l2_read, l2_write, l2_address, i_resp, d_resp);
        end
      end else begin
        if ({l2_read, l2_write, l2_address, i_resp, d_resp} !== {1'b0, 1'b1, 32'h0000_6000, 1'b0, 1'b1}) begin
          tests_failed++;
          $display("FAIL b2b_grant_d n%0d: rd=%b wr=%b addr=%h ir=%b dr=%b", n, l2_read, l2_write, l2_address, i_resp, d_resp);
        end
      end
      @(negedge clk); l2_resp = 1'b0;
      if (n == 5) begin i_read = 1'b0; d_write = 1'b0; end
      #1;
      tests_run++;
      if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
        tests_failed++; $display("FAIL b2b_idle n%0d: rd=%b wr=%b ir=%b dr=%b want 0", n, l2_read, l2_write, i_resp, d_resp);
      end
    end
    tests_run++;
    if (i_count !== 16'd4 || d_count !== 16'd4) begin
      tests_failed++; $display("FAIL b2b_counts: ic=%0d dc=%0d want 4 4", i_count, d_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); i_read = 1'b1; i_address = 32'h0000_7000;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (l2_read !== 1'b1 || l2_address !== 32'h0000_7000) begin
      tests_failed++; $display("FAIL rst_mid_pre: rd=%b addr=%h want 1 00007000", l2_read, l2_address);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_address !== '0 || i_count !== 16'd0 || d_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: rd=%b addr=%h ic=%0d dc=%0d want all 0", l2_read, l2_address, i_count, d_count);
    end
    i_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); d_read = 1'b1; d_address = 32'h0000_8080;
    @(negedge clk); #1;
    tests_run++;
    if ({l2_read, l2_write, l2_address} !== {1'b1, 1'b0, 32'h0000_8080}) begin
      tests_failed++; $display("FAIL rst_mid_fresh_d: rd=%b wr=%b addr=%h", l2_read, l2_write, l2_address);
    end
    l2_resp = 1'b1; l2_rdata = {4{64'h0123_4567_89AB_CDEF}}; #1;
    tests_run++;
    if (d_resp !== 1'b1 || d_rdata !== {4{64'h0123_4567_89AB_CDEF}}) begin
      tests_failed++; $display("FAIL rst_mid_d_resp: d_resp=%b d_rdata=%h", d_resp, d_rdata);
    end
    @(negedge clk); d_read = 1'b0; l2_resp = 1'b0; l2_rdata = '0; #1;
    tests_run++;
    if (i_count !== 16'd0 || d_count !== 16'd1) begin
      tests_failed++; $display("FAIL rst_mid_counts: ic=%0d dc=%0d want 0 1", i_count, d_count);
    end
  endtask

  task automatic test_spurious_resp();
    @(negedge clk); l2_resp = 1'b1; l2_rdata = {32{8'h5A}}; #1;
    tests_run++;
    if ({i_resp, d_resp, l2_read, l2_write} !== 4'b0 || i_rdata !== '0 || d_rdata !== '0) begin
      tests_failed++; $display("FAIL spurious_resp: ir=%b dr=%b rd=%b wr=%b want 0", i_resp, d_resp, l2_read, l2_write);
    end
    @(negedge clk); l2_resp = 1'b0; l2_rdata = '0; #1;
    tests_run++;
    if (i_count !== 16'd0 || d_count !== 16'd1) begin
      tests_failed++; $display("FAIL spurious_counts: ic=%0d dc=%0d want 0 1", i_count, d_count);
    end
  endtask

  task automatic test_saturation();
    int exp;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); s_i_read = 1'b1; s_i_address = 32'(k) << 12;
      @(negedge clk); s_l2_resp = 1'b1; #1;
      tests_run++;
      if (s_i_resp !== 1'b1 || s_l2_address !== (32'(k) << 12)) begin
        tests_failed++; $display("FAIL sat_resp k%0d: i_resp=%b addr=%h", k, s_i_resp, s_l2_address);
      end
      @(negedge clk); s_i_read = 1'b0; s_l2_resp = 1'b0; #1;
      exp = (k < 3) ? k : 3;
      tests_run++;
      if (s_i_count !== exp[1:0] || s_d_count !== 2'd0) begin
        tests_failed++; $display("FAIL sat_count k%0d: ic=%0d dc=%0d want %0d 0", k, s_i_count, s_d_count, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    s_i_read = 1'b0; s_i_address = '0; s_d_read = 1'b0; s_d_write = 1'b0; s_d_address = '0;
    s_d_wdata = '0; s_l2_resp = 1'b0; s_l2_rdata = '0;
    test_reset();
    test_lone_i_read();
    test_lone_d_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_spurious_resp();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-port initiator sitting in front of the shared L2 line cache; it drives the L2's upper-side mem_read/mem_write/mem_resp protocol.
- Accepts 256-bit line requests from the L1 I-cache (read-only) and the L1 D-cache (read/write).
- Grants one requester at a time using round-robin arbitration.
- Routes the L2 response and read data back to the granted requester, and counts completed transactions per port.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width
- CNT_W, 16, width of each saturating transaction counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_resp  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  LINE_W  line data to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line write request, held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write line
- d_resp  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  LINE_W  line data to D-cache
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- l2_address  out  ADDR_W  address to L2
- l2_wdata  out  LINE_W  write data to L2
- l2_resp  in  1  L2 completion pulse
- l2_rdata  in  LINE_W  L2 read data
- i_count  out  CNT_W  completed I transactions, saturating
- d_count  out  CNT_W  completed D transactions, saturating

Behaviour:
- Protocol (all ports):
  - A requester holds its command, address and wdata stable until it sees resp.
  - resp is a single-cycle pulse.
  - The requester may re-request from the cycle after resp.
- Reset (asynchronous): state=IDLE, last_grant=D, counters=0. All outputs are 0: l2_read, l2_write, i_resp, d_resp, counts. l2_address, l2_wdata, i_rdata and d_rdata are also 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - L2 commands are deasserted.
  - At the clock edge, sample i_read and d_read|d_write.
  - Only one side requesting -> go to that side's SERVE state.
  - Both requesting -> grant the side not equal to last_grant. First contention after reset therefore goes to I.
  - Neither requesting -> stay in IDLE.
- SERVE_I:
  - l2_read=1, l2_write=0, l2_address=i_address, combinational from the held inputs.
  - i_rdata=l2_rdata and i_resp=l2_resp, combinational.
  - On l2_resp: go to IDLE, last_grant<=I, i_count increments (saturating at all-ones).
- SERVE_D:
  - l2_read = d_read & ~d_write.
  - l2_write = d_write. If both d_read and d_write are high, the write wins and the read is suppressed.
  - l2_address=d_address, l2_wdata=d_wdata.
  - d_resp and d_rdata are routed as in SERVE_I. On l2_resp: IDLE, last_grant<=D, d_count increments (saturating).
- Response gating:
  - The non-granted port's resp is always 0.
  - The non-granted port's rdata is 0.
  - l2_resp arriving in IDLE is ignored: no resp pulse, no count change.
- Latency:
  - A request visible at edge t makes L2 commands asserted throughout cycle t+1.
  - Completion: requester resp occurs in the same cycle as l2_resp.
  - Mandatory one-cycle IDLE turnaround after every resp; L2 commands are low for that cycle.
- Withdrawn request: if the granted requester drops its command before l2_resp (illegal), the commands follow it low and the state stays until l2_resp. A simulation assertion flags this.
- Reset mid-transaction: immediate return to IDLE and all outputs 0; the in-flight L2 access is abandoned (L2 is reset by the same global reset).

Decomposition:
- Package l2_arb_pkg:
  - typedef enum arb_state_t {IDLE, SERVE_I, SERVE_D}
  - typedef enum grant_t {GRANT_I, GRANT_D}
  - default width constants
- Sub-module sat_counter, parameterised on CNT_W: increment enable, async reset, holds at all-ones. Instantiated twice.

Test Plan:
- Lone I read, addr 0x0000_1000; L2 responds after 5 cycles with line 0xA5..A5 -> l2_read high cycles t+1..t+5; i_resp pulses with i_rdata=0xA5..A5; d_resp stays 0; i_count=1.
- Lone D write, addr 0x0000_2020, wdata 0x1234..; L2 latency 3 -> l2_write=1, l2_read=0, l2_wdata matches; d_resp pulses once; d_count=1; l2 commands low the following cycle.
- I and D request in the same cycle after reset -> I served first; then one IDLE cycle; then D served. Counts end at 1/1.
- Both hold continuous back-to-back requests for 6 transactions -> grants alternate I,D,I,D,I,D; every transaction is separated by exactly one IDLE cycle.
- rst asserted 2 cycles into an I read -> outputs 0 asynchronously, without waiting for a clk edge; after release, a fresh D request is served normally; counts restart from 0.
- CNT_W=2, 5 I reads -> i_count sequence 1,2,3,3,3; d_count stays 0; spurious l2_resp in IDLE causes no resp pulse and no count change.
